ball_motion_ctrl: RTL and testbench

- Sequences the maze ball position once per video frame using direction requests from the motion sensor / cursor logic.
- Steps x_ball/y_ball one pixel per sub-step, up to a commanded speed per frame.
- Before every sub-step it waits for the combinational wall-collision block to settle on the current position, then honours its stop_right/left/up/down flags.
- Detects arrival in the goal region, freezes the ball there, and supports restart to the start position.

---
 rtl/ball_motion_ctrl.sv | 137 +++++++++++++
 tb/tb_ball_motion_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_ctrl.sv
// Frame-paced ball position sequencer: each accepted frame_tick moves the ball one
// pixel per settle/move pair, with collision flags, screen clamping and a goal trap.
module ball_motion_ctrl #(
    parameter int X_START = 40,
    parameter int Y_START = 40,
    parameter int BALL_W  = 10,
    parameter int X_MAX   = 629,
    parameter int Y_MAX   = 469,
    parameter int X_GOAL  = 571,
    parameter int Y_GOAL  = 461
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        dir_right,
    input  logic        dir_left,
    input  logic        dir_up,
    input  logic        dir_down,
    input  logic [3:0]  speed,
    input  logic        restart,
    input  logic        stop_right,
    input  logic        stop_left,
    input  logic        stop_up,
    input  logic        stop_down,
    output logic [10:0] x_ball,
    output logic [10:0] y_ball,
    output logic [4:0]  ball_width,
    output logic        busy,
    output logic        goal,
    output logic        overrun
);
    // state  | meaning
    // IDLE   | waiting for an accepted frame_tick
    // SETTLE | one cycle for collision flags to follow the current position
    // MOVE   | apply one pixel step per axis, decide next sub-step or exit
    // GOAL   | ball frozen in the goal region until restart
    typedef enum logic [1:0] {IDLE, SETTLE, MOVE, GOAL} state_t;

    localparam logic [10:0] X_START_L = 11'(X_START);
    localparam logic [10:0] Y_START_L = 11'(Y_START);
    localparam logic [10:0] X_MAX_L   = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_L   = 11'(Y_MAX);
    localparam logic [10:0] X_GOAL_L  = 11'(X_GOAL);
    localparam logic [10:0] Y_GOAL_L  = 11'(Y_GOAL);

    state_t      state, state_nxt;
    logic        lat_r, lat_l, lat_u, lat_d;
    logic [3:0]  steps;
    logic [10:0] x_nxt, y_nxt;
    logic        can_r, can_l, can_u, can_d;
    logic        accept, goal_hit;

    assign ball_width = 5'(BALL_W);

    always_comb begin
        // opposing requests on one axis cancel each other
        can_r  = lat_r & ~lat_l & ~stop_right & (x_ball < X_MAX_L);
        can_l  = lat_l & ~lat_r & ~stop_left  & (x_ball != 11'd0);
        can_d  = lat_d & ~lat_u & ~stop_down  & (y_ball < Y_MAX_L);
        can_u  = lat_u & ~lat_d & ~stop_up    & (y_ball != 11'd0);

        x_nxt = x_ball;
        if (can_r)      x_nxt = x_ball + 11'd1;
        else if (can_l) x_nxt = x_ball - 11'd1;
        y_nxt = y_ball;
        if (can_d)      y_nxt = y_ball + 11'd1;
        else if (can_u) y_nxt = y_ball - 11'd1;

        goal_hit = (x_nxt >= X_GOAL_L) && (y_nxt >= Y_GOAL_L);
        accept   = (speed != 4'd0) &&
                   ((dir_right ^ dir_left) || (dir_up ^ dir_down));

        state_nxt = state;
        case (state)
            IDLE:   if (frame_tick && accept) state_nxt = SETTLE;
            SETTLE: state_nxt = MOVE;
            MOVE: begin
                if (goal_hit)
                    state_nxt = GOAL;
                else if (steps == 4'd1 || !(can_r | can_l | can_u | can_d))
                    state_nxt = IDLE;
                else
                    state_nxt = SETTLE;
            end
            GOAL:   state_nxt = GOAL;
            default: state_nxt = IDLE;
        endcase
        if (restart) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_ball  <= X_START_L;
            y_ball  <= Y_START_L;
            lat_r   <= 1'b0;
            lat_l   <= 1'b0;
            lat_u   <= 1'b0;
            lat_d   <= 1'b0;
            steps   <= 4'd0;
            busy    <= 1'b0;
            goal    <= 1'b0;
            overrun <= 1'b0;
        end else if (restart) begin
            x_ball  <= X_START_L;
            y_ball  <= Y_START_L;
            lat_r   <= 1'b0;
            lat_l   <= 1'b0;
            lat_u   <= 1'b0;
            lat_d   <= 1'b0;
            steps   <= 4'd0;
            busy    <= 1'b0;
            goal    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= frame_tick && (state != IDLE);
            busy    <= (state_nxt == SETTLE) || (state_nxt == MOVE);
            goal    <= (state_nxt == GOAL);
            if (state == IDLE && frame_tick) begin
                lat_r <= dir_right;
                lat_l <= dir_left;
                lat_u <= dir_up;
                lat_d <= dir_down;
                steps <= speed;
            end
            if (state == MOVE) begin
                x_ball <= x_nxt;
                y_ball <= y_nxt;
                steps  <= steps - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: directed scenarios plus random frames checked against
// a per-frame trajectory model with position-defined virtual walls.
module tb_ball_motion_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        dir_right = 1'b0, dir_left = 1'b0, dir_up = 1'b0, dir_down = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic        restart = 1'b0;
    logic        stop_right, stop_left, stop_up, stop_down;
    logic [10:0] x_ball, y_ball;
    logic [4:0]  ball_width;
    logic        busy, goal, overrun;

    localparam logic [10:0] NO_WALL = 11'h7FF;
    logic [10:0] wr = NO_WALL, wl = NO_WALL, wu = NO_WALL, wd = NO_WALL;

    int n_chk = 0;
    int n_fail = 0;
    int mx = 40, my = 40;
    bit mgoal = 0;

    always #5 clk = ~clk;

    // walls are defined by ball position, as the collision block would report them
    assign stop_right = (x_ball == wr);
    assign stop_left  = (x_ball == wl);
    assign stop_down  = (y_ball == wd);
    assign stop_up    = (y_ball == wu);

    ball_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .dir_right(dir_right), .dir_left(dir_left), .dir_up(dir_up), .dir_down(dir_down),
        .speed(speed), .restart(restart),
        .stop_right(stop_right), .stop_left(stop_left), .stop_up(stop_up), .stop_down(stop_down),
        .x_ball(x_ball), .y_ball(y_ball), .ball_width(ball_width),
        .busy(busy), .goal(goal), .overrun(overrun)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One frame of the reference: returns number of MOVE sub-steps and index of the last real step.
    task automatic model_frame(input bit r, input bit l, input bit u, input bit d, input int spd,
                               output bit acc, output int m, output int last);
        int hx, hy;
        acc  = !mgoal && spd != 0 && ((r ^ l) || (u ^ d));
        m    = 0;
        last = 0;
        if (acc) begin
            for (int k = 1; k <= spd; k++) begin
                m  = k;
                hx = 0;
                hy = 0;
                if (r && !l && mx < 629 && mx != int'(wr)) hx = 1;
                if (l && !r && mx > 0   && mx != int'(wl)) hx = -1;
                if (d && !u && my < 469 && my != int'(wd)) hy = 1;
                if (u && !d && my > 0   && my != int'(wu)) hy = -1;
                if (hx == 0 && hy == 0) break;
                mx   = mx + hx;
                my   = my + hy;
                last = k;
                if (mx >= 571 && my >= 461) begin
                    mgoal = 1;
                    break;
                end
            end
        end
    endtask

    task automatic do_frame(input bit r, input bit l, input bit u, input bit d, input int spd,
                            input bit inject);
        bit acc, gb, inj;
        int m, last, busy_cnt, ov_cnt, last_chg, b1, px, py;
        gb = mgoal;
        @(negedge clk);
        dir_right = r; dir_left = l; dir_up = u; dir_down = d;
        speed = 4'(spd);
        frame_tick = 1'b1;
        model_frame(r, l, u, d, spd, acc, m, last);
        inj = inject && (acc || gb);
        px = int'(x_ball); py = int'(y_ball);
        busy_cnt = 0; ov_cnt = 0; last_chg = 0; b1 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                frame_tick = inj;
                b1 = int'(busy);
                // mid-move request changes must be ignored
                dir_right = 1'($urandom); dir_left = 1'($urandom);
                dir_up = 1'($urandom); dir_down = 1'($urandom);
                speed = 4'($urandom);
            end else if (cyc == 2) begin
                frame_tick = 1'b0;
            end
            if (busy) busy_cnt++;
            if (overrun) ov_cnt++;
            if (int'(x_ball) != px || int'(y_ball) != py) begin
                last_chg = cyc;
                px = int'(x_ball);
                py = int'(y_ball);
            end
        end
        dir_right = 0; dir_left = 0; dir_up = 0; dir_down = 0; speed = 0;
        check("x_final", int'(x_ball), mx);
        check("y_final", int'(y_ball), my);
        check("busy_cycles", busy_cnt, 2 * m);
        check("busy_cycle1", b1, int'(acc));
        check("goal_flag", int'(goal), int'(mgoal));
        check("overrun_pulses", ov_cnt, int'(gb) + int'(inj));
        check("last_change_cycle", last_chg, (last > 0) ? 2 * last + 1 : 0);
    endtask

    task automatic do_restart(input bit with_tick);
        @(negedge clk);
        restart = 1'b1;
        frame_tick = with_tick;
        @(posedge clk); #1;
        restart = 1'b0;
        frame_tick = 1'b0;
        mx = 40; my = 40; mgoal = 0;
        check("rst_x", int'(x_ball), 40);
        check("rst_y", int'(y_ball), 40);
        check("rst_busy", int'(busy), 0);
        check("rst_goal", int'(goal), 0);
        check("rst_overrun", int'(overrun), 0);
        @(posedge clk); #1;
        check("rst_overrun_next", int'(overrun), 0);
        check("rst_busy_next", int'(busy), 0);
    endtask

    task automatic goto_pos(input int tx, input int ty);
        int guard, dlt;
        guard = 0;
        while (mx != tx && guard < 100) begin
            dlt = tx - mx;
            do_frame(dlt > 0, dlt < 0, 0, 0, (dlt > 15 || dlt < -15) ? 15 : (dlt < 0 ? -dlt : dlt), 0);
            guard++;
        end
        while (my != ty && guard < 200) begin
            dlt = ty - my;
            do_frame(0, 0, dlt < 0, dlt > 0, (dlt > 15 || dlt < -15) ? 15 : (dlt < 0 ? -dlt : dlt), 0);
            guard++;
        end
        check("goto_reached", int'(mx == tx && my == ty), 1);
    endtask

    initial begin
        #23;
        check("reset_x", int'(x_ball), 40);
        check("reset_y", int'(y_ball), 40);
        check("reset_busy", int'(busy), 0);
        check("reset_goal", int'(goal), 0);
        check("reset_overrun", int'(overrun), 0);
        check("ball_width", int'(ball_width), 10);
        @(negedge clk);
        rst_n = 1'b1;

        // basic right move, unblocked
        do_frame(1, 0, 0, 0, 3, 0);
        // move down into a wall at y==42
        wd = 11'd42;
        do_frame(0, 0, 0, 1, 5, 0);
        wd = NO_WALL;
        do_restart(0);
        // cancelled horizontal, vertical up
        do_frame(1, 1, 1, 0, 2, 0);
        // no-op frames: speed 0, both axes cancelled
        do_frame(1, 0, 0, 0, 0, 0);
        do_frame(1, 1, 1, 1, 7, 0);

        // right screen clamp
        do_restart(0);
        goto_pos(629, 40);
        do_frame(1, 0, 0, 0, 4, 0);

        // goal region, frozen, overrun, restart with coincident tick
        do_restart(0);
        goto_pos(569, 461);
        do_frame(1, 0, 0, 0, 4, 0);
        do_frame(1, 0, 0, 0, 4, 0);
        do_restart(1);

        // async reset mid-move
        @(negedge clk);
        dir_right = 1; speed = 4'd8; frame_tick = 1;
        @(negedge clk);
        frame_tick = 0; dir_right = 0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_x", int'(x_ball), 40);
        check("async_rst_y", int'(y_ball), 40);
        check("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mx = 40; my = 40; mgoal = 0;

        // overrun tick during a move does not extend it
        do_frame(1, 0, 0, 0, 5, 1);

        // randomized frames with random walls near the ball
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) do_restart(1'($urandom));
            wr = ($urandom_range(0, 1) == 1) ? 11'(mx + $urandom_range(0, 6)) : NO_WALL;
            wl = ($urandom_range(0, 1) == 1 && mx >= 6) ? 11'(mx - $urandom_range(0, 6)) : NO_WALL;
            wd = ($urandom_range(0, 1) == 1) ? 11'(my + $urandom_range(0, 6)) : NO_WALL;
            wu = ($urandom_range(0, 1) == 1 && my >= 6) ? 11'(my - $urandom_range(0, 6)) : NO_WALL;
            do_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end
        wr = NO_WALL; wl = NO_WALL; wu = NO_WALL; wd = NO_WALL;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
